mmio_arbiter: RTL and testbench

// - Shares the single MMIO slave port (14-bit word address, 4-bit byteena, 32-bit data, 1-cycle read latency)

---
 rtl/mmio_pkg.sv | 24 ++
 rtl/mmio_rr_pick.sv | 35 +++
 rtl/mmio_arbiter.sv | 127 ++++++++++++
 tb/tb_mmio_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared widths, owner/state encodings and helpers for the two-master MMIO arbiter.
package mmio_pkg;

  localparam int MMIO_ADDR_W = 14;
  localparam int MMIO_DATA_W = 32;
  localparam int MMIO_BE_W   = 4;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  // One-hot grant mask for a given owner: bit 0 = M0, bit 1 = M1.
  function automatic logic [1:0] owner_mask(owner_t o);
    return (o == OWN_M1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mmio_rr_pick.sv
// Combinational round-robin pick with burst limit; owner is the master granted last cycle.
module mmio_rr_pick
  import mmio_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  input  logic       burst_full,
  input  logic       owner_valid,
  output logic [1:0] grant
);

  logic [1:0] own_mask;
  logic [1:0] oth_mask;
  logic       own_req;
  logic       oth_req;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    grant    = 2'b00;
    own_mask = owner_mask(last_owner);
    oth_mask = ~own_mask;
    own_req  = |(req & own_mask);
    oth_req  = |(req & oth_mask);

    if (!owner_valid) begin
      // From idle a tie goes to whoever did not win last.
      grant = (req == 2'b11) ? oth_mask : req;
    end else if (own_req && (!oth_req || !burst_full)) begin
      grant = own_mask;
    end else if (oth_req) begin
      grant = oth_mask;
    end
  end

endmodule

// File: rtl/mmio_arbiter.sv
// Two-master round-robin arbiter for the MMIO slave port with bounded bursts and 1-cycle read return.
module mmio_arbiter
  import mmio_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   m0_req,
  input  logic [MMIO_ADDR_W-1:0] m0_address,
  input  logic [MMIO_BE_W-1:0]   m0_byteena,
  input  logic [MMIO_DATA_W-1:0] m0_data,
  input  logic                   m0_wren,
  output logic                   m0_gnt,
  output logic                   m0_rvalid,
  output logic [MMIO_DATA_W-1:0] m0_q,
  input  logic                   m1_req,
  input  logic [MMIO_ADDR_W-1:0] m1_address,
  input  logic [MMIO_BE_W-1:0]   m1_byteena,
  input  logic [MMIO_DATA_W-1:0] m1_data,
  input  logic                   m1_wren,
  output logic                   m1_gnt,
  output logic                   m1_rvalid,
  output logic [MMIO_DATA_W-1:0] m1_q,
  output logic [MMIO_ADDR_W-1:0] s_address,
  output logic [MMIO_BE_W-1:0]   s_byteena,
  output logic [MMIO_DATA_W-1:0] s_data,
  output logic                   s_wren,
  output logic                   s_clken,
  input  logic [MMIO_DATA_W-1:0] s_q
);

  localparam int              CNT_W   = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t       state_q, state_d;
  owner_t           last_owner_q, last_owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             resp_valid_q, resp_valid_d;
  owner_t           resp_owner_q, resp_owner_d;

  logic [1:0] pick_grant;
  logic [1:0] grant;
  owner_t     gnt_owner;
  logic       owner_valid;
  logic       burst_full;

  assign owner_valid = (state_q != ARB_IDLE);
  assign burst_full  = (burst_cnt_q == CNT_MAX);

  mmio_rr_pick u_pick (
    .req        ({m1_req, m0_req}),
    .last_owner (last_owner_q),
    .burst_full (burst_full),
    .owner_valid(owner_valid),
    .grant      (pick_grant)
  );

  // Grant is combinational from req, so it is masked while reset is asserted.
  assign grant = pick_grant & {2{reset_n}};

  always_comb begin
    state_d      = ARB_IDLE;
    burst_cnt_d  = '0;
    last_owner_d = last_owner_q;
    resp_valid_d = 1'b0;
    resp_owner_d = resp_owner_q;
    gnt_owner    = pick_grant[1] ? OWN_M1 : OWN_M0;

    if (pick_grant != 2'b00) begin
      state_d      = (gnt_owner == OWN_M1) ? ARB_OWN1 : ARB_OWN0;
      last_owner_d = gnt_owner;
      resp_valid_d = (gnt_owner == OWN_M1) ? ~m1_wren : ~m0_wren;
      resp_owner_d = gnt_owner;
      if (owner_valid && (gnt_owner == last_owner_q)) begin
        burst_cnt_d = burst_full ? burst_cnt_q : burst_cnt_q + CNT_ONE;
      end else begin
        burst_cnt_d = CNT_ONE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= OWN_M1;
      burst_cnt_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_owner_q <= OWN_M0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
    end
  end

  always_comb begin
    m0_gnt    = grant[0];
    m1_gnt    = grant[1];
    s_clken   = |grant;
    s_address = '0;
    s_byteena = '0;
    s_data    = '0;
    s_wren    = 1'b0;
    if (grant[0]) begin
      s_address = m0_address;
      s_byteena = m0_byteena;
      s_data    = m0_data;
      s_wren    = m0_wren;
    end else if (grant[1]) begin
      s_address = m1_address;
      s_byteena = m1_byteena;
      s_data    = m1_data;
      s_wren    = m1_wren;
    end

    m0_rvalid = resp_valid_q && (resp_owner_q == OWN_M0);
    m1_rvalid = resp_valid_q && (resp_owner_q == OWN_M1);
    m0_q      = m0_rvalid ? s_q : '0;
    m1_q      = m1_rvalid ? s_q : '0;
  end

endmodule

// File: tb/tb_mmio_arbiter.sv
// Randomized and directed bench for mmio_arbiter against a queue-free behavioural arbitration model.
module tb_mmio_arbiter;
  import mmio_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [13:0] m0_address = '0, m1_address = '0;
  logic [3:0]  m0_byteena = '0, m1_byteena = '0;
  logic [31:0] m0_data = '0, m1_data = '0;
  logic        m0_wren = 1'b0, m1_wren = 1'b0;
  logic [31:0] s_q = '0;

  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, s_wren, s_clken;
  logic [31:0] m0_q, m1_q, s_data;
  logic [13:0] s_address;
  logic [3:0]  s_byteena;

  logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_s_wren, b_s_clken;
  logic [31:0] b_m0_q, b_m1_q, b_s_data;
  logic [13:0] b_s_address;
  logic [3:0]  b_s_byteena;

  logic [119:0] all_out;
  assign all_out = {m0_gnt, m0_rvalid, m0_q, m1_gnt, m1_rvalid, m1_q,
                    s_address, s_byteena, s_data, s_wren, s_clken};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mmio_arbiter #(.BURST_MAX(4)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .m0_req(m0_req), .m0_address(m0_address), .m0_byteena(m0_byteena), .m0_data(m0_data),
    .m0_wren(m0_wren), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_q(m0_q),
    .m1_req(m1_req), .m1_address(m1_address), .m1_byteena(m1_byteena), .m1_data(m1_data),
    .m1_wren(m1_wren), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_q(m1_q),
    .s_address(s_address), .s_byteena(s_byteena), .s_data(s_data), .s_wren(s_wren),
    .s_clken(s_clken), .s_q(s_q)
  );

  mmio_arbiter #(.BURST_MAX(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n),
    .m0_req(m0_req), .m0_address(m0_address), .m0_byteena(m0_byteena), .m0_data(m0_data),
    .m0_wren(m0_wren), .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_q(b_m0_q),
    .m1_req(m1_req), .m1_address(m1_address), .m1_byteena(m1_byteena), .m1_data(m1_data),
    .m1_wren(m1_wren), .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_q(b_m1_q),
    .s_address(b_s_address), .s_byteena(b_s_byteena), .s_data(b_s_data), .s_wren(b_s_wren),
    .s_clken(b_s_clken), .s_q(s_q)
  );

  // Model state per instance: index 0 = BURST_MAX 4, index 1 = BURST_MAX 1.
  int own [2];
  int cnt [2];
  int last [2];
  int bmax [2] = '{4, 1};
  bit pend_v;
  int pend_o;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      own[i]  = -1;
      cnt[i]  = 0;
      last[i] = 1;
    end
    pend_v = 1'b0;
    pend_o = -1;
  endtask

  // Which master wins this cycle (-1 = nobody), from the arbitration rules.
  function automatic int model_pick(int i, bit r0, bit r1);
    if (!r0 && !r1) return -1;
    if (r0 && !r1)  return 0;
    if (r1 && !r0)  return 1;
    if (own[i] < 0) return 1 - last[i];
    if (cnt[i] < bmax[i]) return own[i];
    return 1 - own[i];
  endfunction

  task automatic model_advance(int i, int g);
    if (g < 0) begin
      own[i] = -1;
      cnt[i] = 0;
    end else begin
      if (g == own[i]) cnt[i] = (cnt[i] + 1 > bmax[i]) ? bmax[i] : cnt[i] + 1;
      else             cnt[i] = 1;
      own[i]  = g;
      last[i] = g;
    end
  endtask

  // One clock cycle: drive at negedge, compare all outputs, advance the model.
  task automatic cycle(input bit r0, input bit w0, input logic [13:0] a0, input logic [31:0] d0,
                       input logic [3:0] e0, input bit r1, input bit w1, input logic [13:0] a1,
                       input logic [31:0] d1, input logic [3:0] e1, output int g, output int gb);
    logic [1:0]  exp_g, exp_gb;
    logic [49:0] exp_bus;
    logic [49:0] got_bus;
    bit          exp_rv0, exp_rv1, exp_w;
    logic [31:0] exp_q0, exp_q1;
    @(negedge clock);
    m0_req = r0; m0_wren = w0; m0_address = a0; m0_data = d0; m0_byteena = e0;
    m1_req = r1; m1_wren = w1; m1_address = a1; m1_data = d1; m1_byteena = e1;
    s_q = $urandom;
    #1;
    g  = model_pick(0, r0, r1);
    gb = model_pick(1, r0, r1);
    exp_g  = {g == 1, g == 0};
    exp_gb = {gb == 1, gb == 0};
    exp_w  = (g == 0) ? w0 : (g == 1) ? w1 : 1'b0;
    if (g == 0)      exp_bus = {a0, e0, d0};
    else if (g == 1) exp_bus = {a1, e1, d1};
    else             exp_bus = '0;
    got_bus = {s_address, s_byteena, s_data};
    exp_rv0 = pend_v && (pend_o == 0);
    exp_rv1 = pend_v && (pend_o == 1);
    exp_q0  = exp_rv0 ? s_q : 32'h0;
    exp_q1  = exp_rv1 ? s_q : 32'h0;

    n_cmp++;
    if ({m1_gnt, m0_gnt} !== exp_g) begin
      n_err++; $display("FAIL gnt t=%0t got %b want %b", $time, {m1_gnt, m0_gnt}, exp_g);
    end
    n_cmp++;
    if ({s_clken, s_wren} !== {g >= 0, exp_w}) begin
      n_err++; $display("FAIL clken_wren t=%0t got %b want %b", $time, {s_clken, s_wren}, {g >= 0, exp_w});
    end
    n_cmp++;
    if (got_bus !== exp_bus) begin
      n_err++; $display("FAIL slave_bus t=%0t got %h want %h", $time, got_bus, exp_bus);
    end
    n_cmp++;
    if ({m1_rvalid, m0_rvalid} !== {exp_rv1, exp_rv0}) begin
      n_err++; $display("FAIL rvalid t=%0t got %b want %b", $time, {m1_rvalid, m0_rvalid}, {exp_rv1, exp_rv0});
    end
    n_cmp++;
    if ({m1_q, m0_q} !== {exp_q1, exp_q0}) begin
      n_err++; $display("FAIL rdata t=%0t got %h want %h", $time, {m1_q, m0_q}, {exp_q1, exp_q0});
    end
    n_cmp++;
    if ({b_m1_gnt, b_m0_gnt} !== exp_gb) begin
      n_err++; $display("FAIL gnt_burst1 t=%0t got %b want %b", $time, {b_m1_gnt, b_m0_gnt}, exp_gb);
    end

    model_advance(0, g);
    model_advance(1, gb);
    pend_v = (g >= 0) && !exp_w;
    pend_o = g;
  endtask

  task automatic idle(output int g, output int gb);
    cycle(0, 0, 14'h0, 32'h0, 4'h0, 0, 0, 14'h0, 32'h0, 4'h0, g, gb);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset_n = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    #2;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    m0_req = 1'b1;
    m1_req = 1'b1;
    s_q = 32'hFFFF_FFFF;
    #12;
    n_cmp++;
    if (all_out !== '0) begin
      n_err++; $display("FAIL reset_outputs got %h want 0", all_out);
    end
    n_cmp++;
    if ({b_m0_gnt, b_m1_gnt, b_s_clken} !== 3'b000) begin
      n_err++; $display("FAIL reset_outputs_b1 got %b want 000", {b_m0_gnt, b_m1_gnt, b_s_clken});
    end
    apply_reset();
  endtask

  task automatic test_single_read();
    int g, gb;
    cycle(1, 0, 14'h0000, 32'h0, 4'hF, 0, 0, 14'h0, 32'h0, 4'h0, g, gb);
    idle(g, gb);
    n_cmp++;
    if ({m0_rvalid, m1_rvalid, m0_q} !== {2'b10, s_q}) begin
      n_err++; $display("FAIL single_read got %b/%h want 10/%h", {m0_rvalid, m1_rvalid}, m0_q, s_q);
    end
  endtask

  task automatic test_tie();
    int g, gb;
    apply_reset();
    cycle(1, 0, 14'h0010, 32'h0, 4'hF, 1, 1, 14'h0000, 32'h155, 4'b0011, g, gb);
    n_cmp++;
    if (m0_gnt !== 1'b1) begin
      n_err++; $display("FAIL tie_first got m0_gnt=%b want 1", m0_gnt);
    end
    cycle(0, 0, 14'h0, 32'h0, 4'h0, 1, 1, 14'h0000, 32'h155, 4'b0011, g, gb);
    n_cmp++;
    if ({m1_gnt, s_wren, s_address, s_byteena, s_data} !== {1'b1, 1'b1, 14'h0, 4'b0011, 32'h155}) begin
      n_err++; $display("FAIL tie_m1_write got %b %b %h %b %h", m1_gnt, s_wren, s_address, s_byteena, s_data);
    end
    idle(g, gb);
    n_cmp++;
    if (m1_rvalid !== 1'b0) begin
      n_err++; $display("FAIL tie_no_m1_rvalid got %b want 0", m1_rvalid);
    end
  endtask

  task automatic test_burst();
    int g, gb;
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      cycle(1, 0, 14'(k), $urandom, 4'hF, 1, 0, 14'(k + 100), $urandom, 4'hF, g, gb);
      n_cmp++;
      if ({m1_gnt, b_m1_gnt} !== {1'((k / 4) % 2), 1'(k % 2)}) begin
        n_err++; $display("FAIL burst_pattern k=%0d got %b%b want %0d%0d", k, m1_gnt, b_m1_gnt, (k / 4) % 2, k % 2);
      end
    end
    idle(g, gb);
  endtask

  task automatic test_back_to_back();
    int g, gb;
    int n_clk = 0;
    int n_rv = 0;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      if (k < 3) cycle(1, 0, 14'(k), 32'h0, 4'hF, 0, 0, 14'h0, 32'h0, 4'h0, g, gb);
      else       idle(g, gb);
      n_clk += int'(s_clken);
      n_rv  += int'(m0_rvalid);
    end
    n_cmp++;
    if ({n_clk, n_rv} !== {32'd3, 32'd3}) begin
      n_err++; $display("FAIL back_to_back clken=%0d rvalid=%0d want 3/3", n_clk, n_rv);
    end
  endtask

  task automatic test_reset_mid();
    int g, gb;
    apply_reset();
    cycle(0, 0, 14'h0, 32'h0, 4'h0, 1, 0, 14'h0123, 32'h0, 4'hF, g, gb);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (all_out !== '0) begin
      n_err++; $display("FAIL reset_mid_outputs got %h want 0", all_out);
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    cycle(1, 0, 14'h0001, 32'h0, 4'hF, 1, 0, 14'h0002, 32'h0, 4'hF, g, gb);
    n_cmp++;
    if ({m0_gnt, m1_rvalid} !== 2'b10) begin
      n_err++; $display("FAIL reset_mid_release got gnt0=%b rv1=%b want 1 0", m0_gnt, m1_rvalid);
    end
    idle(g, gb);
    idle(g, gb);
  endtask

  task automatic test_drop();
    int g, gb;
    int m1_hits = 0;
    apply_reset();
    cycle(1, 0, 14'h0020, 32'h0, 4'hF, 0, 0, 14'h0, 32'h0, 4'h0, g, gb);
    m1_hits += int'(m1_gnt);
    cycle(1, 0, 14'h0021, 32'h0, 4'hF, 1, 0, 14'h0030, 32'h0, 4'hF, g, gb);
    m1_hits += int'(m1_gnt);
    cycle(1, 0, 14'h0022, 32'h0, 4'hF, 0, 0, 14'h0, 32'h0, 4'h0, g, gb);
    m1_hits += int'(m1_gnt);
    idle(g, gb);
    m1_hits += int'(m1_rvalid);
    n_cmp++;
    if (m1_hits != 0) begin
      n_err++; $display("FAIL drop_m1_activity got %0d want 0", m1_hits);
    end
    // Back in IDLE with last owner M0, a tie must now go to M1.
    cycle(1, 0, 14'h0023, 32'h0, 4'hF, 1, 0, 14'h0031, 32'h0, 4'hF, g, gb);
    n_cmp++;
    if (m1_gnt !== 1'b1) begin
      n_err++; $display("FAIL drop_idle_tie got m1_gnt=%b want 1", m1_gnt);
    end
    idle(g, gb);
  endtask

  task automatic test_random();
    int g, gb;
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom % 4) != 0, 1'($urandom), 14'($urandom), $urandom, 4'($urandom),
            ($urandom % 3) != 0, 1'($urandom), 14'($urandom), $urandom, 4'($urandom), g, gb);
    end
    idle(g, gb);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_read();
    test_tie();
    test_burst();
    test_back_to_back();
    test_reset_mid();
    test_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
